pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_if.sv | 28 ++
 rtl/pc_unit.sv | 113 +++++++++++
 tb/tb_pc_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// pc_unit_if: redirect/hazard inputs and PC outputs of the fetch PC unit.
interface pc_unit_if #(
  parameter int len_data = 32
);
  logic                stall;
  logic                halt_in;
  logic [2:0]          PCSrc;
  logic [len_data-1:0] jump_address;
  logic [len_data-1:0] register_address;
  logic [len_data-1:0] branch_address;
  logic [len_data-1:0] pc_out;
  logic [len_data-1:0] pc_plus4;
  logic                redirect;
  logic                halted;
  logic                pc_error;

  modport master (
    output stall, halt_in, PCSrc,
    output jump_address, register_address, branch_address,
    input  pc_out, pc_plus4, redirect, halted, pc_error
  );

  modport slave (
    input  stall, halt_in, PCSrc,
    input  jump_address, register_address, branch_address,
    output pc_out, pc_plus4, redirect, halted, pc_error
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with IDLE/RUN/HALTED control and single-step.
// Optional target bound/alignment check enabled by PC_BOUND_CHECK_EN.
module pc_unit #(
  parameter int                  len_data   = 32,
  parameter logic [len_data-1:0] RESET_PC   = '0,
  parameter int                  IMEM_DEPTH = 2048
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    enable,
  input  logic    step_mode,
  input  logic    step,
  pc_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t              state;
  logic [len_data-1:0] pc_q;
  logic [len_data-1:0] pc_inc;
  logic [len_data-1:0] target;
  logic                redir_q;
  logic                halt_q;
  logic                advance;
  logic                redir_sel;
  logic                load;

  assign pc_inc  = pc_q + len_data'(4);
  assign advance = (state == RUN) && (!step_mode || step);

  // Redirect wins over stall; jump > register > branch.
  always_comb begin
    target    = pc_inc;
    redir_sel = 1'b1;
    if (bus.PCSrc[2])
      target = bus.jump_address;
    else if (bus.PCSrc[1])
      target = bus.register_address;
    else if (bus.PCSrc[0])
      target = bus.branch_address;
    else
      redir_sel = 1'b0;
    load = redir_sel || !bus.stall;
  end

`ifdef PC_BOUND_CHECK_EN
  localparam logic [len_data:0] pc_limit =
    (len_data+1)'(IMEM_DEPTH) << 2;

  logic err_q;
  logic fault;

  assign fault = load &&
    (({1'b0, target} >= pc_limit) ||
     (target[1:0] != 2'b00));
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      redir_q <= 1'b0;
      halt_q  <= 1'b0;
`ifdef PC_BOUND_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      redir_q <= 1'b0;
      case (state)
        IDLE: begin
          if (enable)
            state <= RUN;
        end
        RUN: begin
          if (advance) begin
            if (bus.halt_in) begin
              state  <= HALTED;
              halt_q <= 1'b1;
            end
`ifdef PC_BOUND_CHECK_EN
            else if (fault) begin
              err_q  <= 1'b1;
              state  <= HALTED;
              halt_q <= 1'b1;
            end
`endif
            else if (load) begin
              pc_q    <= target;
              redir_q <= redir_sel;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc_out   = pc_q;
  assign bus.pc_plus4 = pc_inc;
  assign bus.redirect = redir_q;
  assign bus.halted   = halt_q;
`ifdef PC_BOUND_CHECK_EN
  assign bus.pc_error = err_q;
`else
  assign bus.pc_error = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with hand-computed PC sequences.
module tb_pc_unit;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic step_mode;
  logic step;

  int n_cmp = 0;
  int n_err = 0;

  pc_unit_if #(.len_data(32)) bus ();

  pc_unit #(
    .len_data  (32),
    .RESET_PC  (32'h0),
    .IMEM_DEPTH(2048)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .step_mode(step_mode),
    .step     (step),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input logic [2:0] src,
                         input logic [31:0] j,
                         input logic [31:0] r,
                         input logic [31:0] b);
    bus.PCSrc            = src;
    bus.jump_address     = j;
    bus.register_address = r;
    bus.branch_address   = b;
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;
    bus.stall   = 1'b0;
    bus.halt_in = 1'b0;
    set_src(3'b000, 32'h0, 32'h0, 32'h0);

    tick();
    check("rst_pc", bus.pc_out, 32'h0);
    check("rst_plus4", bus.pc_plus4, 32'h4);
    check("rst_redir", bus.redirect, 1'b0);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_err", bus.pc_error, 1'b0);

    // IDLE ignores redirects
    reset = 1'b1;
    set_src(3'b100, 32'h100, 32'h0, 32'h0);
    tick();
    check("idle_pc", bus.pc_out, 32'h0);
    check("idle_redir", bus.redirect, 1'b0);

    set_src(3'b000, 32'h0, 32'h0, 32'h0);
    enable = 1'b1;
    tick();
    check("run0", bus.pc_out, 32'h0);
    tick();
    check("run1", bus.pc_out, 32'h4);
    tick();
    check("run2", bus.pc_out, 32'h8);
    tick();
    check("run3", bus.pc_out, 32'hC);
    check("run_redir", bus.redirect, 1'b0);

    set_src(3'b101, 32'h100, 32'h0, 32'h200);
    bus.stall = 1'b1;
    tick();
    check("jmp_pc", bus.pc_out, 32'h100);
    check("jmp_redir", bus.redirect, 1'b1);
    set_src(3'b000, 32'h0, 32'h0, 32'h0);
    bus.stall = 1'b0;
    tick();
    check("jmp_next", bus.pc_out, 32'h104);
    check("redir_pulse", bus.redirect, 1'b0);

    bus.stall = 1'b1;
    tick();
    check("stall_hold", bus.pc_out, 32'h104);
    bus.stall = 1'b0;

    set_src(3'b011, 32'h0, 32'h40, 32'h200);
    tick();
    check("reg_sel", bus.pc_out, 32'h40);
    set_src(3'b001, 32'h0, 32'h0, 32'h80);
    tick();
    check("br_sel", bus.pc_out, 32'h80);
    set_src(3'b110, 32'h100, 32'h40, 32'h0);
    tick();
    check("jmp_over_reg", bus.pc_out, 32'h100);

`ifndef PC_BOUND_CHECK_EN
    set_src(3'b100, 32'hFFFF_FFFC, 32'h0, 32'h0);
    tick();
    check("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
    check("wrap_plus4", bus.pc_plus4, 32'h0);
    set_src(3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    check("wrap_next", bus.pc_out, 32'h0);
`endif

    set_src(3'b100, 32'h10, 32'h0, 32'h0);
    tick();
    check("pre_halt", bus.pc_out, 32'h10);
    bus.halt_in = 1'b1;
    set_src(3'b100, 32'h300, 32'h0, 32'h0);
    tick();
    check("halt_pc", bus.pc_out, 32'h10);
    check("halt_flag", bus.halted, 1'b1);
    check("halt_redir", bus.redirect, 1'b0);
    bus.halt_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halted_pc", bus.pc_out, 32'h10);
      check("halted_hold", bus.halted, 1'b1);
    end
    reset = 1'b0;
    tick();
    check("unhalt_pc", bus.pc_out, 32'h0);
    check("unhalt_flag", bus.halted, 1'b0);

    // step pulses on cycles 2 and 5 after reset release
    set_src(3'b000, 32'h0, 32'h0, 32'h0);
    reset     = 1'b1;
    step_mode = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step = (c == 2) || (c == 5);
      tick();
      check("step_seq", bus.pc_out,
            (c >= 5) ? 32'h8 : (c >= 2) ? 32'h4 : 32'h0);
    end
    step      = 1'b0;
    step_mode = 1'b0;
    tick();
    check("step_off", bus.pc_out, 32'hC);

    set_src(3'b100, 32'h500, 32'h0, 32'h0);
    reset = 1'b0;
    tick();
    check("midrst_pc", bus.pc_out, 32'h0);
    check("midrst_redir", bus.redirect, 1'b0);

    reset = 1'b1;
    set_src(3'b000, 32'h0, 32'h0, 32'h0);
    tick();
    set_src(3'b100, 32'h2000, 32'h0, 32'h0);
    tick();
`ifdef PC_BOUND_CHECK_EN
    check("bound_pc", bus.pc_out, 32'h0);
    check("bound_err", bus.pc_error, 1'b1);
    check("bound_halt", bus.halted, 1'b1);
    tick();
    check("bound_sticky", bus.pc_error, 1'b1);
`else
    check("bound_pc", bus.pc_out, 32'h2000);
    check("bound_err", bus.pc_error, 1'b0);
    check("bound_halt", bus.halted, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
